// File: rtl/audio_rx_array.sv
// Multi-lane I2S / left-justified audio receiver with a shared capture FSM and FWFT half-frame FIFO.
// Optional per-drop counter on drop_count enabled by defining AUDIO_RX_DROP_CNT_EN.
module audio_rx_array #(
   parameter int NUM_LANES  = 1,
   parameter int SAMPLE_W   = 24,
   parameter int OUT_W      = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       i2s_lj_,
   input  logic                       lrck,
   input  logic                       sclk,
   input  logic [NUM_LANES-1:0]       sdata,
   output logic [NUM_LANES*OUT_W-1:0] out_data,
   output logic                       out_right,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       ovfl,
   input  logic                       ovfl_clr,
   output logic [15:0]                drop_count
);

   localparam int CNT_W = $clog2(SAMPLE_W + 1);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int EW    = NUM_LANES * OUT_W + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);
   localparam logic [OUT_W-1:0] MSB_ONE  = OUT_W'(1) << (OUT_W - 1);

   typedef enum logic [1:0] {IDLE, DELAY, SHIFT, HOLD} state_t;

   // Places bit b at MSB-first position pos; positions past OUT_W fall off, which is the truncation.
   function automatic logic [OUT_W-1:0] place_bit(input logic [OUT_W-1:0] w,
                                                  input logic [CNT_W-1:0] pos,
                                                  input logic             b);
      logic [OUT_W-1:0] mask;
      mask = MSB_ONE >> pos;
      return b ? (w | mask) : (w & ~mask);
   endfunction

   logic                 lrck_p0, lrck_p1, lrck_p2;
   logic                 sclk_p0, sclk_p1, sclk_p2;
   logic [NUM_LANES-1:0] sdata_p0, sdata_p1;
   logic [1:0]           arm;
   logic                 armed, lrck_edge, sclk_rise;

   // Stage p0/p1: synchronisers; p2 holds the previous level for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         {lrck_p0, lrck_p1, lrck_p2} <= '0;
         {sclk_p0, sclk_p1, sclk_p2} <= '0;
         sdata_p0 <= '0;
         sdata_p1 <= '0;
         arm      <= '0;
      end else begin
         {lrck_p0, lrck_p1, lrck_p2} <= {lrck, lrck_p0, lrck_p1};
         {sclk_p0, sclk_p1, sclk_p2} <= {sclk, sclk_p0, sclk_p1};
         sdata_p0 <= sdata;
         sdata_p1 <= sdata_p0;
         if (arm != 2'd3) arm <= arm + 2'd1;
      end
   end

   // Edges are ignored until the chain refills, so a high lrck at reset release is not a frame start.
   assign armed     = (arm == 2'd3);
   assign lrck_edge = armed && (lrck_p1 ^ lrck_p2);
   assign sclk_rise = armed && sclk_p1 && !sclk_p2;

   state_t                              state, next_state;
   logic   [CNT_W-1:0]                  cnt;
   logic   [NUM_LANES-1:0][OUT_W-1:0]   word_p0, word_nxt;
   logic                                chan_right;
   logic                                push, frame_start;

   always_comb begin
      next_state  = state;
      push        = 1'b0;
      frame_start = 1'b0;
      if (!enable) begin
         next_state = IDLE;
      end else begin
         if (lrck_edge) frame_start = 1'b1;
         case (state)
            IDLE, HOLD:
               if (lrck_edge) next_state = i2s_lj_ ? DELAY : SHIFT;
            DELAY:
               if (lrck_edge)      next_state = i2s_lj_ ? DELAY : SHIFT;
               else if (sclk_rise) next_state = SHIFT;
            SHIFT:
               if (lrck_edge) begin
                  push       = 1'b1;
                  next_state = i2s_lj_ ? DELAY : SHIFT;
               end else if (sclk_rise && cnt == LAST_BIT) begin
                  push       = 1'b1;
                  next_state = HOLD;
               end
            default: next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      word_nxt = word_p0;
      if (state == SHIFT && sclk_rise && !lrck_edge)
         for (int l = 0; l < NUM_LANES; l++)
            word_nxt[l] = place_bit(word_p0[l], cnt, sdata_p1[l]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         if (frame_start) cnt <= '0;
         else if (state == SHIFT && sclk_rise && cnt != LAST_BIT) cnt <= cnt + 1'b1;
      end
   end

   // Stage p0: lane words; cleared at each frame start so unreceived LSBs read as zero
   always_ff @(posedge clk) begin
      if (frame_start) begin
         word_p0    <= '0;
         chan_right <= i2s_lj_ ? lrck_p1 : ~lrck_p1;
      end else if (state == SHIFT && sclk_rise) begin
         word_p0 <= word_nxt;
      end
   end

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          empty, full, pop, wr_en, drop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = out_valid && out_ready;
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovfl   <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         if (drop)          ovfl <= 1'b1;
         else if (ovfl_clr) ovfl <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= {chan_right, word_nxt};
   end

   assign out_valid               = !empty;
   assign {out_right, out_data}   = empty ? '0 : mem[rd_ptr[AW-1:0]];

`ifdef AUDIO_RX_DROP_CNT_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [15:0] drop_cnt_p0;

   // A drop coinciding with a clear still counts as the first drop of the new interval.
   always_ff @(posedge clk) begin
      if (reset)         drop_cnt_p0 <= '0;
      else if (ovfl_clr) drop_cnt_p0 <= drop ? 16'd1 : 16'd0;
      else if (drop)     drop_cnt_p0 <= sat_inc(drop_cnt_p0);
   end

   assign drop_count = drop_cnt_p0;
`else
   assign drop_count = '0;
`endif

endmodule
